// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the SRAM-like port arbiter: requester ids,
// the forwarded request-field bundle and the grant-lock states.
package sram_like_arbiter_pkg;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  // wr + size + wstrb + addr + wdata
  localparam int ARB_MEM_REQ_WD = 71;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // A pending (not yet accepted) request pins the grant to its owner.
  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_state_e;

  function automatic lock_state_e lock_of(input logic id);
    return (id == ARB_ID_DATA) ? LK_DATA : LK_INST;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// Owner FIFO: remembers which requester issued each accepted transaction
// so in-order mem_data_ok responses can be routed back. 1 bit wide,
// OUTSTANDING deep (power of two, so pointers wrap naturally).
module sram_like_arbiter_id_fifo #(
  parameter int OUTSTANDING = 4,
  parameter int ID_FIFO_AW  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  logic [OUTSTANDING-1:0] ids;
  logic [ID_FIFO_AW-1:0]  wptr;
  logic [ID_FIFO_AW-1:0]  rptr;
  logic [ID_FIFO_AW:0]    count;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == (ID_FIFO_AW+1)'(OUTSTANDING));
  assign empty   = (count == '0);
  assign head    = ids[rptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Id storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) ids[wptr] <= push_id;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates the single SRAM-like memory port between instruction fetch
// and the data path, locks a grant until accepted, and routes in-order
// responses back through an owner FIFO.
// Optional macro SRAM_ARB_RR_EN: round-robin on ties instead of fixed
// data priority.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int ID_FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  lock_state_e lock_state;
  lock_state_e lock_next;
  logic        owner;
  logic        pick;
  logic        req_sel;
  logic        accept;
  logic        full;
  logic        empty;
  logic        head;
  mem_req_t    inst_fields;
  mem_req_t    data_fields;
  logic [ARB_MEM_REQ_WD-1:0] req_bus;

  // Read data goes straight to the requesters; the arbiter never looks at it.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  // Remember who was accepted last so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (reset)       last_grant <= ARB_ID_INST;
    else if (accept) last_grant <= owner;
  end

  // Unlocked choice: alternate on ties, otherwise whoever is asking.
  always_comb begin
    pick = data_req ? ARB_ID_DATA : ARB_ID_INST;
    if (data_req && inst_req)
      pick = (last_grant == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
  end
`else
  // Unlocked choice: data is older in program order, so it always wins.
  always_comb begin
    pick = data_req ? ARB_ID_DATA : ARB_ID_INST;
  end
`endif

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) lock_state <= LK_NONE;
    else       lock_state <= lock_next;
  end

  // Grant, handshake outputs and lock transitions.
  always_comb begin
    lock_next    = lock_state;
    owner        = pick;
    case (lock_state)
      LK_INST: owner = ARB_ID_INST;
      LK_DATA: owner = ARB_ID_DATA;
      default: owner = pick;
    endcase
    req_sel      = (owner == ARB_ID_DATA) ? data_req : inst_req;
    // Full gate uses pre-pop occupancy; a same-cycle pop frees a slot next cycle.
    mem_req      = req_sel & ~full & ~reset;
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & (owner == ARB_ID_INST);
    data_addr_ok = accept & (owner == ARB_ID_DATA);
    if (accept)
      lock_next = LK_NONE;
    else if (mem_req)
      lock_next = lock_of(owner);
    else if (!req_sel)
      // An abandoned lock would starve the other requester forever.
      lock_next = LK_NONE;
  end

  assign inst_fields = '{wr: 1'b0, size: 2'd2, wstrb: 4'b0000,
                         addr: inst_addr, wdata: 32'h0};
  assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};
  assign req_bus     = (owner == ARB_ID_DATA) ? data_fields : inst_fields;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = req_bus;

  // Responses are in order, so the FIFO head names the requester.
  assign inst_data_ok = mem_data_ok & ~reset & ~empty & (head == ARB_ID_INST);
  assign data_data_ok = mem_data_ok & ~reset & ~empty & (head == ARB_ID_DATA);

  sram_like_arbiter_id_fifo #(
    .OUTSTANDING (OUTSTANDING),
    .ID_FIFO_AW  (ID_FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (owner),
    .pop     (mem_data_ok & ~reset),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

`ifndef SYNTHESIS
  // Protocol monitors.
  always_ff @(posedge clk) begin
    if (!reset && lock_state != LK_NONE && !req_sel)
      $error("sram_like_arbiter: locked requester dropped its request");
    if (!reset && mem_data_ok && empty)
      $warning("sram_like_arbiter: mem_data_ok with nothing outstanding, ignored");
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter. A scoreboard queue holds the
// expected owner of every accepted transaction; each mem_data_ok pops it.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic sb[$];   // expected owner ids: 0 = inst, 1 = data

  sram_like_arbiter #(.OUTSTANDING(4), .ID_FIFO_AW(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive point: just after the rising edge; checks follow one time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 0;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Return n responses one per cycle, comparing each against the scoreboard.
  task automatic drain(input int n, input string tag);
    logic exp;
    for (int i = 0; i < n; i++) begin
      step();
      mem_data_ok = 1; mem_rdata = 32'hA000_0000 + i;
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s_underflow[%0d]: scoreboard empty, inst_data_ok=%b data_data_ok=%b",
                 tag, i, inst_data_ok, data_data_ok);
      end else begin
        exp = sb.pop_front();
        if (inst_data_ok !== (exp == 1'b0) || data_data_ok !== (exp == 1'b1)) begin
          n_fail++;
          $display("FAIL %s_order[%0d]: inst_data_ok=%b data_data_ok=%b, required owner=%s",
                   tag, i, inst_data_ok, data_data_ok, exp ? "data" : "inst");
        end
      end
    end
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    step(); #1;
    n_checks++;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req/aok/aok/dok/dok=%b, required 00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    idle_inputs();
    step();
    reset = 0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_req: mem_req=%b, required 0", mem_req);
    end
  endtask

  task automatic test_single_fetch();
    step();
    inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    #1;
    n_checks++;
    if (mem_req !== 1 || mem_addr !== 32'hBFC0_0000 || mem_wr !== 0 || mem_size !== 2'd2 ||
        mem_wstrb !== 4'b0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_fields: req=%b addr=%h wr=%b size=%0d wstrb=%b wdata=%h, required 1 bfc00000 0 2 0000 0",
               mem_req, mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata);
    end
    n_checks++;
    if (inst_addr_ok !== 1 || data_addr_ok !== 0) begin
      n_fail++;
      $display("FAIL fetch_addr_ok: inst=%b data=%b, required 1 0", inst_addr_ok, data_addr_ok);
    end
    sb.push_back(1'b0);
    step();
    inst_req = 0; mem_addr_ok = 0;
    #1;
    n_checks++;
    if (inst_addr_ok !== 0) begin
      n_fail++; $display("FAIL fetch_addr_ok_pulse: inst_addr_ok=%b, required 0", inst_addr_ok);
    end
    step();
    mem_data_ok = 1; mem_rdata = 32'h2401_0001;
    #1;
    n_checks++;
    if (inst_data_ok !== 1 || data_data_ok !== 0) begin
      n_fail++;
      $display("FAIL fetch_data_ok: inst=%b data=%b, required 1 0", inst_data_ok, data_data_ok);
    end
    void'(sb.pop_front());
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_tie();
    logic        exp_id;
    logic [31:0] exp_addr;
    step();
    inst_req = 1; inst_addr = 32'h2000;
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h1000;
    data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
    #1;
    n_checks++;
    if (mem_wr !== 1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h1000 || data_addr_ok !== 1 ||
        inst_addr_ok !== 0) begin
      n_fail++;
      $display("FAIL tie_first: wr=%b wstrb=%b addr=%h daok=%b iaok=%b, required 1 0011 1000 1 0",
               mem_wr, mem_wstrb, mem_addr, data_addr_ok, inst_addr_ok);
    end
    sb.push_back(1'b1);
    step();
    data_req = 0;
    #1;
    n_checks++;
    if (mem_addr !== 32'h2000 || inst_addr_ok !== 1 || mem_wr !== 0 || mem_wstrb !== 4'b0) begin
      n_fail++;
      $display("FAIL tie_inst_next: addr=%h iaok=%b wr=%b wstrb=%b, required 2000 1 0 0000",
               mem_addr, inst_addr_ok, mem_wr, mem_wstrb);
    end
    sb.push_back(1'b0);
    step();
    inst_req = 0; mem_addr_ok = 0;
    drain(2, "tie_a");

    // Second round: tie, then a fresh data request races the waiting fetch.
    step();
    inst_req = 1; inst_addr = 32'h2004;
    data_req = 1; data_wr = 0; data_addr = 32'h1004; mem_addr_ok = 1;
    #1;
    n_checks++;
    if (data_addr_ok !== 1 || mem_addr !== 32'h1004) begin
      n_fail++;
      $display("FAIL tie_round2: daok=%b addr=%h, required 1 1004", data_addr_ok, mem_addr);
    end
    sb.push_back(1'b1);
    step();
    data_addr = 32'h1008;
`ifdef SRAM_ARB_RR_EN
    exp_id = 1'b0; exp_addr = 32'h2004;
`else
    exp_id = 1'b1; exp_addr = 32'h1008;
`endif
    #1;
    n_checks++;
    if (mem_addr !== exp_addr || inst_addr_ok !== !exp_id || data_addr_ok !== exp_id) begin
      n_fail++;
      $display("FAIL tie_second: addr=%h iaok=%b daok=%b, required %h %b %b",
               mem_addr, inst_addr_ok, data_addr_ok, exp_addr, !exp_id, exp_id);
    end
    sb.push_back(exp_id);
    step();
    if (exp_id) data_req = 0; else inst_req = 0;
    #1;
    n_checks++;
    if (inst_addr_ok !== exp_id || data_addr_ok !== !exp_id) begin
      n_fail++;
      $display("FAIL tie_remaining: iaok=%b daok=%b, required %b %b",
               inst_addr_ok, data_addr_ok, exp_id, !exp_id);
    end
    sb.push_back(!exp_id);
    step();
    inst_req = 0; data_req = 0; mem_addr_ok = 0;
    drain(3, "tie_b");
  endtask

  task automatic test_lock();
    step();
    inst_req = 1; inst_addr = 32'h3000; mem_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_req = 1; data_wr = 0; data_addr = 32'h1100;
      end
      #1;
      n_checks++;
      if (mem_req !== 1 || mem_addr !== 32'h3000 || inst_addr_ok !== 0 || data_addr_ok !== 0) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: req=%b addr=%h iaok=%b daok=%b, required 1 3000 0 0",
                 c, mem_req, mem_addr, inst_addr_ok, data_addr_ok);
      end
      step();
    end
    mem_addr_ok = 1;
    #1;
    n_checks++;
    if (mem_addr !== 32'h3000 || inst_addr_ok !== 1 || data_addr_ok !== 0) begin
      n_fail++;
      $display("FAIL lock_accept: addr=%h iaok=%b daok=%b, required 3000 1 0",
               mem_addr, inst_addr_ok, data_addr_ok);
    end
    sb.push_back(1'b0);
    step();
    inst_req = 0;
    #1;
    n_checks++;
    if (mem_addr !== 32'h1100 || data_addr_ok !== 1) begin
      n_fail++;
      $display("FAIL lock_then_data: addr=%h daok=%b, required 1100 1", mem_addr, data_addr_ok);
    end
    sb.push_back(1'b1);
    step();
    data_req = 0; mem_addr_ok = 0;
    drain(2, "lock");
  endtask

  // Four accepts D,I,D,I fill the FIFO; then a pop frees one slot.
  task automatic test_full();
    logic exp;
    for (int i = 0; i < 4; i++) begin
      step();
      data_req = (i % 2 == 0); inst_req = (i % 2 == 1);
      data_addr = 32'h4000 + 4 * i; inst_addr = 32'h5000 + 4 * i;
      data_wr = 0; mem_addr_ok = 1;
      #1;
      n_checks++;
      if (data_addr_ok !== data_req || inst_addr_ok !== inst_req) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: daok=%b iaok=%b, required %b %b",
                 i, data_addr_ok, inst_addr_ok, data_req, inst_req);
      end
      sb.push_back(data_req);
    end
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h4100;
    #1;
    n_checks++;
    if (mem_req !== 0 || data_addr_ok !== 0) begin
      n_fail++;
      $display("FAIL full_block: mem_req=%b daok=%b, required 0 0", mem_req, data_addr_ok);
    end
    step();
    mem_data_ok = 1;
    #1;
    exp = sb.pop_front();
    n_checks++;
    if (mem_req !== 0 || data_data_ok !== exp || inst_data_ok !== !exp) begin
      n_fail++;
      $display("FAIL full_pop: mem_req=%b ddok=%b idok=%b, required 0 %b %b",
               mem_req, data_data_ok, inst_data_ok, exp, !exp);
    end
    step();
    mem_data_ok = 0;
    #1;
    n_checks++;
    if (mem_req !== 1 || data_addr_ok !== 1) begin
      n_fail++;
      $display("FAIL full_refill: mem_req=%b daok=%b, required 1 1", mem_req, data_addr_ok);
    end
    sb.push_back(1'b1);
    step();
    data_req = 0; inst_req = 1;
    #1;
    n_checks++;
    if (mem_req !== 0) begin
      n_fail++; $display("FAIL full_again: mem_req=%b, required 0", mem_req);
    end
    step();
    inst_req = 0; mem_addr_ok = 0;
    drain(4, "order");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      step();
      data_req = 1; data_addr = 32'h6000 + 4 * i; mem_addr_ok = 1;
    end
    step();
    data_req = 0; mem_addr_ok = 0;
    reset = 1;
    step();
    reset = 0;
    sb.delete();
    mem_data_ok = 1;
    #1;
    n_checks++;
    if (inst_data_ok !== 0 || data_data_ok !== 0) begin
      n_fail++;
      $display("FAIL reset_stray: idok=%b ddok=%b, required 0 0", inst_data_ok, data_data_ok);
    end
    step();
    mem_data_ok = 0;
    // Four new accepts must all fit, proving occupancy restarted at zero.
    for (int i = 0; i < 4; i++) begin
      step();
      inst_req = 1; inst_addr = 32'h7000 + 4 * i; mem_addr_ok = 1;
      #1;
      n_checks++;
      if (inst_addr_ok !== 1) begin
        n_fail++;
        $display("FAIL reset_refill[%0d]: iaok=%b, required 1", i, inst_addr_ok);
      end
      sb.push_back(1'b0);
    end
    step();
    inst_req = 0; mem_addr_ok = 0;
    drain(4, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_lock();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
